// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, imem address/data and IF/ID payload.
// Build with FETCH_PERF_CNT_EN defined to carry the fetch/stall performance counters.
interface if_stage_if;
  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            if_id_valid;
  logic            fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_count;
  logic [XLEN-1:0] stall_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, instr,
    output pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fetch_fault,
    output fetch_count, stall_count
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, instr,
    input  pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fetch_fault,
    input  fetch_count, stall_count
  );
`else
  modport master (
    input  stall, redirect_valid, redirect_pc, instr,
    output pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fetch_fault
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, instr,
    input  pc, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fetch_fault
  );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture, stall/redirect/fault handling.
// Optional FETCH_PERF_CNT_EN adds free-running fetch and stall counters.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned IMEM_WORDS = 256
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int unsigned     XLEN     = 32;
  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_STALL,
    ACT_FAULT,
    ACT_FETCH
  } act_e;

  act_e            act;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_pc_plus4_q;
  logic            valid_q;
  logic            fault_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Per-edge action select; redirect beats stall, stall beats fault.
  always_comb begin
    act = ACT_FETCH;
    if (bus.redirect_valid)  act = ACT_REDIRECT;
    else if (bus.stall)      act = ACT_STALL;
    else if (pc_q >= PC_LIMIT) act = ACT_FAULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (act)
        ACT_REDIRECT: begin
          pc_q          <= bus.redirect_pc & ~XLEN'(3);
          instr_q       <= NOP_INSTR;
          id_pc_q       <= '0;
          id_pc_plus4_q <= '0;
          valid_q       <= 1'b0;
          fault_q       <= 1'b0;
        end
        ACT_STALL: begin
        end
        ACT_FAULT: begin
          // PC parks on the bad address until a redirect or reset.
          instr_q       <= NOP_INSTR;
          id_pc_q       <= '0;
          id_pc_plus4_q <= '0;
          valid_q       <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: begin
          pc_q          <= pc_plus4;
          instr_q       <= bus.instr;
          id_pc_q       <= pc_q;
          id_pc_plus4_q <= pc_plus4;
          valid_q       <= 1'b1;
          fault_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc       = id_pc_q;
  assign bus.if_id_pc_plus4 = id_pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_fault    = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (act == ACT_FETCH) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (act == ACT_STALL) stall_cnt_q <= stall_cnt_q + XLEN'(1);
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed plan plus random stall/redirect traffic
// against a behavioural fetch model; expected post-edge state is queued for the monitor.
module tb_if_stage;
  localparam int unsigned IMEM_WORDS = 256;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk;
  logic rst;
  if_stage_if bus();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [IMEM_WORDS];
  assign bus.instr = imem[bus.pc[9:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] plus4;
    logic        valid;
    logic        fault;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  logic [31:0] m_pc, m_instr, m_ipc, m_plus4, m_fc, m_sc;
  logic        m_valid, m_fault;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_plus4 = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  task automatic bubble();
    m_instr = NOP; m_ipc = 32'h0; m_plus4 = 32'h0; m_valid = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge with the post-edge state settled.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    exp_t e;
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    if (rv) begin
      m_pc = (rpc / 4) * 4;
      bubble();
      m_fault = 1'b0;
    end else if (st) begin
      m_sc = m_sc + 1;
    end else if (m_pc >= 32'(IMEM_WORDS * 4)) begin
      bubble();
      m_fault = 1'b1;
    end else begin
      m_instr = imem[m_pc / 4];
      m_ipc   = m_pc;
      m_plus4 = m_pc + 4;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      m_fault = 1'b0;
      m_fc    = m_fc + 1;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.plus4 = m_plus4;
    e.valid = m_valid; e.fault = m_fault; e.fc = m_fc; e.sc = m_sc;
    q.push_back(e);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.if_id_instr, NOP);
    chk("rst_ipc", bus.if_id_pc, 32'h0);
    chk("rst_plus4", bus.if_id_pc_plus4, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'h0);
  endtask

  // Asserts reset between edges, checks it acted at once, holds across one edge, releases.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_values();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare every post-edge DUT state against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("if_id_instr", bus.if_id_instr, e.instr);
        chk("if_id_pc", bus.if_id_pc, e.ipc);
        chk("if_id_pc_plus4", bus.if_id_pc_plus4, e.plus4);
        chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(e.fault));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", bus.fetch_count, e.fc);
        chk("stall_count", bus.stall_count, e.sc);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(IMEM_WORDS); i++) imem[i] = $urandom;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;

    // Run to PC=0x10, then reset while stall and redirect are both high.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk("pc_before_reset", bus.pc, 32'h10);
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
    do_reset();

    // Two fetches, two stalls, one release.
    step(1'b0, 1'b0, 32'h0);
    chk("first_ipc", bus.if_id_pc, 32'h0);
    chk("first_instr", bus.if_id_instr, imem[0]);
    step(1'b0, 1'b0, 32'h0);
    chk("second_ipc", bus.if_id_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("stall_pc", bus.pc, 32'h8);
    chk("stall_ipc", bus.if_id_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    chk("release_ipc", bus.if_id_pc, 32'h8);
    chk("release_pc", bus.pc, 32'hC);

    // Redirect from 0x44 to misaligned 0x2E.
    while (bus.pc != 32'h44) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h2E);
    chk("redir_pc", bus.pc, 32'h2C);
    chk("redir_valid", 32'(bus.if_id_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_next_ipc", bus.if_id_pc, 32'h2C);

    // Stall and redirect together, then back-to-back redirects.
    step(1'b1, 1'b1, 32'h20);
    chk("stall_redir_pc", bus.pc, 32'h20);
    chk("stall_redir_instr", bus.if_id_instr, NOP);
    step(1'b0, 1'b1, 32'h104);
    step(1'b0, 1'b1, 32'h3FD);
    chk("redir_3fc", bus.pc, 32'h3FC);

    // Last legal word, then the out-of-range halt, then recovery.
    step(1'b0, 1'b0, 32'h0);
    chk("last_word_valid", 32'(bus.if_id_valid), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    chk("fault_flag", 32'(bus.fetch_fault), 32'h1);
    chk("fault_pc_hold", bus.pc, 32'h400);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    chk("fault_cleared", 32'(bus.fetch_fault), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Random traffic, including redirects past the memory end.
    for (int i = 0; i < 300; i++) begin
      logic st, rv;
      st = ($urandom_range(0, 9) < 2);
      rv = ($urandom_range(0, 9) < 1);
      step(st, rv, 32'($urandom_range(0, 32'h44F)));
    end

    // Counter scenario from a fresh reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    chk("perf_redirect_pc", bus.pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_5", bus.fetch_count, 32'd5);
    chk("perf_stall_3", bus.stall_count, 32'd3);
`endif

    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the architectural PC register and drives it to the combinational instruction memory (256 words, word index PC[9:2]).
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage branch/jump redirects with IF/ID flush, and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0) injected into IF/ID.
- IMEM_WORDS, 256: instruction memory depth in words. Legal fetch range is 0 to IMEM_WORDS*4-4.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- RedirectValid  in  1  taken branch or jump resolved in EX.
- RedirectPC  in  32  redirect target.
- PC  out  32  fetch address to instruction memory.
- Instr  in  32  instruction word returned combinationally for PC.
- IF_ID_Instr  out  32  registered instruction.
- IF_ID_PC  out  32  registered fetch address.
- IF_ID_PCPlus4  out  32  registered PC+4 (link value).
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- FetchFault  out  1  registered flag: the last fetch attempt was out of range.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-stall or mid-redirect. Reset values:
  - PC = RESET_PC
  - IF_ID_Instr = NOP_INSTR
  - IF_ID_PC = 0, IF_ID_PCPlus4 = 0
  - IF_ID_Valid = 0, FetchFault = 0
- Latency: PC is presented in cycle N; Instr is captured into IF/ID at the end of cycle N and is visible in cycle N+1.
- Per rising edge, mutually exclusive actions in priority order:
  1. RedirectValid=1 (overrides Stall):
     - PC <= {RedirectPC[31:2], 2'b00}; low bits are ignored.
     - IF/ID <= bubble: Instr=NOP_INSTR, PC=0, PCPlus4=0, Valid=0.
     - FetchFault <= 0.
  2. Stall=1: PC, IF/ID and FetchFault all hold.
  3. Out-of-range (PC >= IMEM_WORDS*4, no redirect, no stall):
     - PC holds; fetch halts until a redirect or reset.
     - IF/ID <= bubble.
     - FetchFault <= 1.
  4. Normal:
     - PC <= PC+4, 32-bit modulo.
     - IF_ID_Instr <= Instr, IF_ID_PC <= PC, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
     - FetchFault <= 0.
- Wrap-around: PC+4 from 32'hFFFF_FFFC wraps to 0. This is unreachable in practice because the out-of-range rule halts fetch first.
- Stall and Redirect in the same cycle: the redirect wins and the instruction currently in IF/ID is discarded. The hazard unit must not rely on it.
- Consecutive redirects: each one reloads PC; IF/ID stays a bubble.
- The IF/ID outputs and FetchFault come straight from registers. No combinational path from inputs to IF_ID_* outputs.
- PC output is the PC register itself, with no input-to-PC combinational path.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs FetchCount (32) and StallCount (32), both reset to 0.
  - FetchCount increments on every edge where IF_ID_Valid is loaded with 1.
  - StallCount increments on every edge where action 2 (Stall) is taken.
  - Both counters wrap modulo 2^32 and are unaffected by redirect.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Assert Reset mid-run at PC=0x10 -> PC=0x0, IF_ID_Valid=0, IF_ID_Instr=0x00000013 immediately, before the next edge. Release, then 3 edges -> IF_ID_PC sequence 0x0, 0x4, 0x8, each with the matching Instr and Valid=1.
- Run to PC=0x8, hold Stall for 2 cycles -> PC stays 0x8 and IF_ID_PC stays 0x4. Release -> next edge IF_ID_PC=0x8, PC=0xC.
- At PC=0x44, pulse RedirectValid with RedirectPC=0x2E -> next edge PC=0x2C, IF_ID_Valid=0, IF_ID_Instr=0x13. Following edge -> IF_ID_PC=0x2C, Valid=1.
- Assert Stall and RedirectValid (RedirectPC=0x20) together -> PC=0x20 and IF/ID is a bubble; the redirect wins.
- Redirect to 0x400 -> next edge PC=0x400. Following edge: FetchFault=1, Valid=0, PC holds at 0x400 over repeated edges. Redirect to 0x0 -> FetchFault=0 and fetch resumes.
- With FETCH_PERF_CNT_EN: 5 normal fetches, 3 stall cycles, 1 redirect -> FetchCount=5, StallCount=3.
